// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32I constants and the branch control FSM state type.
package rv32_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        IDLE,
        STALL,
        FLUSH
    } bcu_state_t;

endpackage

// File: rtl/branch_hazard_detect.sv
// branch_hazard_detect: classifies operand hazards of a branch in ID against EX and MEM producers.
module branch_hazard_detect (
    input  logic       i_is_br,
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    input  logic [4:0] i_ex_rd,
    input  logic       i_ex_reg_write,
    input  logic       i_ex_mem_read,
    input  logic [4:0] i_mem_rd,
    input  logic       i_mem_mem_read,
    output logic       o_haz1,
    output logic       o_haz2
);
    logic w_ex_dep, w_mem_dep;

    // x0 is never a real destination, so it cannot create a dependency
    assign w_ex_dep  = (i_ex_rd != 5'd0) && ((i_ex_rd == i_id_rs1) || (i_ex_rd == i_id_rs2));
    assign w_mem_dep = (i_mem_rd != 5'd0) && ((i_mem_rd == i_id_rs1) || (i_mem_rd == i_id_rs2));

    assign o_haz2 = i_is_br && i_ex_reg_write && i_ex_mem_read && w_ex_dep;
    assign o_haz1 = i_is_br && !o_haz2 && ((i_ex_reg_write && w_ex_dep) || (i_mem_mem_read && w_mem_dep));

endmodule

// File: rtl/branch_control_unit.sv
// branch_control_unit: stalls ID-stage branches on operand hazards, redirects and flushes on taken
// branches, and counts resolved and taken conditional branches.
module branch_control_unit
    import rv32_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            hold,
    input  logic            id_valid,
    input  logic [6:0]      id_opcode,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      ex_rd,
    input  logic            ex_reg_write,
    input  logic            ex_mem_read,
    input  logic [4:0]      mem_rd,
    input  logic            mem_reg_write,
    input  logic            mem_mem_read,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic            bolha,
    output logic            stall_pc,
    output logic            stall_ifid,
    output logic            flush_ifid,
    output logic            pc_sel,
    output logic [XLEN-1:0] pc_redirect,
    output logic [XLEN-1:0] br_count,
    output logic [XLEN-1:0] taken_count
);
    bcu_state_t      r_state;
    logic [XLEN-1:0] r_pc_redirect, r_br_count, r_taken_count;
    logic            w_is_br, w_haz1, w_haz2, w_stall, w_flush, w_resolve, w_unused;

    // a MEM-stage producer only matters when it is a load, so its write enable is not needed
    assign w_unused = mem_reg_write;

    assign w_is_br = id_valid && (id_opcode == OPC_BRANCH);

    branch_hazard_detect u_haz (
        .i_is_br        (w_is_br),
        .i_id_rs1       (id_rs1),
        .i_id_rs2       (id_rs2),
        .i_ex_rd        (ex_rd),
        .i_ex_reg_write (ex_reg_write),
        .i_ex_mem_read  (ex_mem_read),
        .i_mem_rd       (mem_rd),
        .i_mem_mem_read (mem_mem_read),
        .o_haz1         (w_haz1),
        .o_haz2         (w_haz2)
    );

    assign w_stall   = (r_state == STALL) || ((r_state == IDLE) && (w_haz1 || w_haz2));
    assign w_flush   = (r_state == FLUSH);
    assign w_resolve = (r_state == IDLE) && w_is_br && !w_haz1 && !w_haz2;

    assign stall_pc    = w_stall;
    assign stall_ifid  = w_stall;
    assign bolha       = w_stall || w_flush;
    assign flush_ifid  = w_flush;
    assign pc_sel      = w_flush;
    assign pc_redirect = r_pc_redirect;
    assign br_count    = r_br_count;
    assign taken_count = r_taken_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_pc_redirect <= '0;
            r_br_count    <= '0;
            r_taken_count <= '0;
        end else if (!hold) begin
            r_state <= ((r_state == IDLE) && w_haz2) ? STALL :
                       (w_resolve && branch_taken)   ? FLUSH : IDLE;
            if (w_resolve) begin
                r_br_count <= r_br_count + XLEN'(1);
                if (branch_taken) begin
                    r_taken_count <= r_taken_count + XLEN'(1);
                    r_pc_redirect <= branch_target;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_control_unit.sv
// tb_branch_control_unit: directed test-plan scenarios plus randomized traffic checked against a
// cycle-level behavioural model; a narrow second instance exercises counter wrap.
module tb_branch_control_unit;

    logic        clk = 1'b0;
    logic        reset, hold, id_valid, ex_reg_write, ex_mem_read, mem_reg_write, mem_mem_read, branch_taken;
    logic [6:0]  id_opcode;
    logic [4:0]  id_rs1, id_rs2, ex_rd, mem_rd;
    logic [31:0] branch_target;
    logic        bolha, stall_pc, stall_ifid, flush_ifid, pc_sel;
    logic [31:0] pc_redirect, br_count, taken_count;
    logic        n_bolha, n_stall_pc, n_stall_ifid, n_flush_ifid, n_pc_sel;
    logic [3:0]  n_pc_redirect, n_br_count, n_taken_count;

    int checks = 0;
    int errors = 0;

    // model: remaining stall-state cycles, pending flush, and the architectural registers
    int          m_stall;
    bit          m_flush;
    logic [31:0] m_br, m_tk, m_pc;

    always #5 clk = ~clk;

    branch_control_unit #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .hold(hold), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .mem_mem_read(mem_mem_read), .branch_taken(branch_taken), .branch_target(branch_target),
        .bolha(bolha), .stall_pc(stall_pc), .stall_ifid(stall_ifid), .flush_ifid(flush_ifid),
        .pc_sel(pc_sel), .pc_redirect(pc_redirect), .br_count(br_count), .taken_count(taken_count)
    );

    branch_control_unit #(.XLEN(4)) dut_n (
        .clk(clk), .reset(reset), .hold(hold), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .mem_mem_read(mem_mem_read), .branch_taken(branch_taken), .branch_target(branch_target[3:0]),
        .bolha(n_bolha), .stall_pc(n_stall_pc), .stall_ifid(n_stall_ifid), .flush_ifid(n_flush_ifid),
        .pc_sel(n_pc_sel), .pc_redirect(n_pc_redirect), .br_count(n_br_count), .taken_count(n_taken_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit dep(input logic [4:0] rd);
        return rd != 5'd0 && (rd == id_rs1 || rd == id_rs2);
    endfunction

    // stall cycles a branch in ID needs before it can resolve
    function automatic int need_stalls();
        if (!(id_valid && id_opcode == 7'b1100011)) return 0;
        if (ex_reg_write && ex_mem_read && dep(ex_rd)) return 2;
        if ((ex_reg_write && dep(ex_rd)) || (mem_mem_read && dep(mem_rd))) return 1;
        return 0;
    endfunction

    task automatic quiet();
        hold = 0; id_valid = 0; id_opcode = 7'd0; id_rs1 = 0; id_rs2 = 0;
        ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0;
        mem_rd = 0; mem_reg_write = 0; mem_mem_read = 0;
        branch_taken = 0; branch_target = 32'd0;
    endtask

    task automatic branch(input logic [4:0] rs1, input logic [4:0] rs2, input logic tk, input logic [31:0] tgt);
        quiet();
        id_valid = 1; id_opcode = 7'b1100011; id_rs1 = rs1; id_rs2 = rs2;
        branch_taken = tk; branch_target = tgt;
    endtask

    // check outputs at the falling edge, advance the model, then step past the rising edge
    task automatic cyc();
        int  n;
        bit  e_stall, e_flush;
        @(negedge clk);
        n = need_stalls();
        e_flush = m_flush;
        e_stall = !m_flush && (m_stall > 0 || n > 0);
        check("stall_pc", stall_pc, e_stall);
        check("stall_ifid", stall_ifid, e_stall);
        check("bolha", bolha, e_stall || e_flush);
        check("flush_ifid", flush_ifid, e_flush);
        check("pc_sel", pc_sel, e_flush);
        check("pc_redirect", pc_redirect, m_pc);
        check("br_count", br_count, m_br);
        check("taken_count", taken_count, m_tk);
        check("n_br_count", n_br_count, m_br[3:0]);
        check("n_taken_count", n_taken_count, m_tk[3:0]);
        if (reset) begin
            m_stall = 0; m_flush = 0; m_br = 0; m_tk = 0; m_pc = 0;
        end else if (!hold) begin
            if (m_flush) m_flush = 0;
            else if (m_stall > 0) m_stall--;
            else if (n == 2) m_stall = 1;
            else if (n == 0 && id_valid && id_opcode == 7'b1100011) begin
                m_br++;
                if (branch_taken) begin
                    m_tk++;
                    m_pc = branch_target;
                    m_flush = 1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        quiet();
        reset = 1;
        cyc();
        reset = 0;
    endtask

    initial begin
        quiet();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        m_stall = 0; m_flush = 0; m_br = 0; m_tk = 0; m_pc = 0;
        reset = 0;
        check("rst_pc_sel", pc_sel, 0);
        check("rst_br", br_count, 0);
        check("rst_redirect", pc_redirect, 0);
        cyc();

        // taken BEQ x5,x5 with target 0x100
        branch(5, 5, 1, 32'h100); cyc();
        check("beq_pc_sel", pc_sel, 1);
        check("beq_flush", flush_ifid, 1);
        check("beq_redirect", pc_redirect, 32'h100);
        check("beq_br", br_count, 1);
        check("beq_tk", taken_count, 1);
        quiet(); cyc(); cyc();

        // lw x3 in EX, bne x3,x4 in ID: two stall cycles then resolve
        branch(3, 4, 0, 32'h200); ex_rd = 3; ex_reg_write = 1; ex_mem_read = 1;
        cyc(); check("lu_br_t0", br_count, 1);
        cyc(); check("lu_br_t1", br_count, 1);
        ex_reg_write = 0; ex_mem_read = 0; cyc();
        check("lu_br_t2", br_count, 2);
        quiet(); cyc();

        // add x7 in EX, blt x7,x1 in ID: one stall cycle
        branch(7, 1, 0, 32'h0); ex_rd = 7; ex_reg_write = 1;
        cyc(); check("alu_br_t0", br_count, 2);
        ex_reg_write = 0; cyc();
        check("alu_br_t1", br_count, 3);
        // x0 destination never stalls
        branch(0, 1, 0, 32'h0); ex_rd = 0; ex_reg_write = 1; ex_mem_read = 1;
        cyc(); check("x0_br", br_count, 4);
        quiet(); cyc();

        // taken branch, then hold for 3 cycles during FLUSH
        branch(2, 9, 1, 32'h340); cyc();
        quiet(); hold = 1;
        repeat (3) begin
            branch(1, 2, 1, 32'h999); hold = 1; cyc();
            check("hold_pc_sel", pc_sel, 1);
            check("hold_br", br_count, 5);
        end
        quiet(); cyc();
        check("hold_release_pc_sel", pc_sel, 0);
        check("hold_tk", taken_count, 2);

        // reset arriving during FLUSH discards the redirect
        branch(4, 6, 1, 32'h480); cyc();
        check("pre_rst_pc_sel", pc_sel, 1);
        do_reset();
        check("mid_rst_pc_sel", pc_sel, 0);
        check("mid_rst_br", br_count, 0);
        check("mid_rst_redirect", pc_redirect, 0);
        cyc();

        // narrow instance: 16 not-taken branches wrap a 4-bit counter back to zero
        repeat (15) begin branch(1, 2, 0, 32'h0); cyc(); end
        check("wrap_pre", n_br_count, 4'hF);
        branch(1, 2, 0, 32'h0); cyc();
        check("wrap_br", n_br_count, 0);
        check("wrap_tk", n_taken_count, 0);
        check("wrap_wide_br", br_count, 16);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            id_valid      = ($urandom_range(0, 9) < 8);
            id_opcode     = ($urandom_range(0, 2) != 0) ? 7'b1100011 : 7'($urandom);
            id_rs1        = 5'($urandom_range(0, 3));
            id_rs2        = 5'($urandom_range(0, 3));
            ex_rd         = 5'($urandom_range(0, 3));
            ex_reg_write  = 1'($urandom);
            ex_mem_read   = 1'($urandom);
            mem_rd        = 5'($urandom_range(0, 3));
            mem_reg_write = 1'($urandom);
            mem_mem_read  = 1'($urandom);
            branch_taken  = 1'($urandom);
            branch_target = $urandom;
            hold          = ($urandom_range(0, 6) == 0);
            reset         = ($urandom_range(0, 99) == 0);
            cyc();
        end
        reset = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
